// File: rtl/noc_types.sv
// Shared NoC types for the node sink: flit layout, field widths, FSM states.
package noc_types;

   localparam int DATA_W   = 8;
   localparam int ADDR_W   = 4;
   // Destination address sits in the low bits of a head flit's data field.
   localparam int DEST_LSB = 0;

   typedef enum logic [1:0] {
      HEAD = 2'd0,
      BODY = 2'd1,
      TAIL = 2'd2
   } flit_kind_t;

   typedef struct packed {
      flit_kind_t          kind;
      logic [DATA_W-1:0]   data;
   } flit_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OPEN   = 2'd1,
      CLOSE  = 2'd2,
      REJECT = 2'd3
   } sink_state_t;

   // Extract the destination address carried by a head flit.
   function automatic logic [ADDR_W-1:0] head_dest(input flit_t f);
      return f.data[DEST_LSB +: ADDR_W];
   endfunction

endpackage

// File: rtl/node_port_if.sv
// Upstream link into a sink node: flit plus enable forward, ack/rej back.
interface node_port;
   import noc_types::*;

   logic  enable;
   flit_t flit;
   logic  ack;
   logic  rej;

   modport up (
      output enable,
      output flit,
      input  ack,
      input  rej
   );

   modport down (
      input  enable,
      input  flit,
      output ack,
      output rej
   );

endinterface

// File: rtl/sink_fifo.sv
// Payload buffer with a commit pointer: entries written during a packet stay
// invisible to the reader until the TAIL commits them, and can be discarded
// by rolling the write pointer back to the last commit point.
module sink_fifo
   import noc_types::*;
#(
   parameter int DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_last,
   input  logic              rollback,
   input  logic              rd_ready,
   output logic              full,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic              rd_valid
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   typedef logic [PTR_W-1:0] ptr_t;

   localparam ptr_t PTR_ONE = ptr_t'(1);

   // Each entry holds {last, data}.
   logic [DATA_W:0] mem_q [DEPTH];

   ptr_t rd_q, rd_d;
   ptr_t wr_q, wr_d;
   ptr_t cm_q, cm_d;

   logic wr_fire_s;
   logic rd_fire_s;

   // Status flags and next-pointer computation; full uses current pointers so
   // a read only frees space for a write on the following cycle.
   always_comb begin
      full      = (wr_q[IDX_W-1:0] == rd_q[IDX_W-1:0]) && (wr_q[IDX_W] != rd_q[IDX_W]);
      rd_valid  = (rd_q != cm_q);
      rd_fire_s = rd_valid && rd_ready;
      wr_fire_s = wr_en && !full && !rollback;

      rd_d = rd_q;
      wr_d = wr_q;
      cm_d = cm_q;

      if (rd_fire_s) begin
         rd_d = rd_q + PTR_ONE;
      end else begin
         rd_d = rd_q;
      end

      if (rollback) begin
         wr_d = cm_q;
      end else if (wr_fire_s) begin
         wr_d = wr_q + PTR_ONE;
         if (wr_last) begin
            cm_d = wr_q + PTR_ONE;
         end else begin
            cm_d = cm_q;
         end
      end else begin
         wr_d = wr_q;
      end
   end

   // Pointer registers; reset empties the buffer without touching storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q <= '0;
         wr_q <= '0;
         cm_q <= '0;
      end else begin
         rd_q <= rd_d;
         wr_q <= wr_d;
         cm_q <= cm_d;
      end
   end

   // Storage array write port; contents need no reset as pointers gate visibility.
   always_ff @(posedge clk) begin
      if (wr_fire_s) begin
         mem_q[wr_q[IDX_W-1:0]] <= {wr_last, wr_data};
      end
   end

   // Read port presents the entry at the read pointer.
   always_comb begin
      rd_data = mem_q[rd_q[IDX_W-1:0]][DATA_W-1:0];
      rd_last = mem_q[rd_q[IDX_W-1:0]][DATA_W];
   end

endmodule

// File: rtl/node_sink.sv
// Sink endpoint of a NoC link: accepts packets addressed to NODE_ADDR,
// buffers their payload flits and releases them to the consumer only once
// the whole packet has arrived. Misaddressed, malformed or overflowing
// packets are refused with rej and leave no trace in the buffer.
module node_sink
   import noc_types::*;
#(
   parameter logic [ADDR_W-1:0] NODE_ADDR  = {ADDR_W{1'b0}},
   parameter int                FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   node_port.down            port,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
);

   sink_state_t state_q, state_d;
   logic        ack_q, ack_d;
   logic        rej_q, rej_d;
   logic        busy_q, busy_d;

   logic        fifo_wr_en;
   logic        fifo_wr_last;
   logic        fifo_rollback;
   logic        fifo_full;
   logic        is_payload;

   // Next-state logic and buffer control for the packet FSM.
   always_comb begin
      state_d       = state_q;
      fifo_wr_en    = 1'b0;
      fifo_wr_last  = 1'b0;
      fifo_rollback = 1'b0;
      is_payload    = (port.flit.kind == BODY) || (port.flit.kind == TAIL);

      case (state_q)
         IDLE: begin
            if (port.enable && (port.flit.kind == HEAD)) begin
               if (head_dest(port.flit) == NODE_ADDR) begin
                  state_d = OPEN;
               end else begin
                  state_d = REJECT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         OPEN: begin
            if (!port.enable) begin
               // Sender abandoned the packet: discard quietly.
               fifo_rollback = 1'b1;
               state_d       = IDLE;
            end else if (is_payload) begin
               if (fifo_full) begin
                  fifo_rollback = 1'b1;
                  state_d       = REJECT;
               end else begin
                  fifo_wr_en   = 1'b1;
                  fifo_wr_last = (port.flit.kind == TAIL);
                  if (port.flit.kind == TAIL) begin
                     state_d = CLOSE;
                  end else begin
                     state_d = OPEN;
                  end
               end
            end else begin
               // A HEAD (or unknown kind) inside a packet is a protocol error.
               fifo_rollback = 1'b1;
               state_d       = REJECT;
            end
         end
         CLOSE: begin
            if (port.enable) begin
               state_d = CLOSE;
            end else begin
               state_d = IDLE;
            end
         end
         REJECT: begin
            if (port.enable) begin
               state_d = REJECT;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ack_d  = (state_d == OPEN) || (state_d == CLOSE);
      rej_d  = (state_d == REJECT);
      busy_d = (state_d != IDLE);
   end

   // FSM state and its registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ack_q   <= 1'b0;
         rej_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         rej_q   <= rej_d;
         busy_q  <= busy_d;
      end
   end

   assign port.ack = ack_q;
   assign port.rej = rej_q;
   assign busy     = busy_q;

   sink_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (fifo_wr_en),
      .wr_data  (port.flit.data),
      .wr_last  (fifo_wr_last),
      .rollback (fifo_rollback),
      .rd_ready (out_ready),
      .full     (fifo_full),
      .rd_data  (out_data),
      .rd_last  (out_last),
      .rd_valid (out_valid)
   );

endmodule

// File: doc/node_sink.md
NODE_SINK -- requirements
Module: node_sink

Interface
REQ-001 SHALL have parameter NODE_ADDR, default 0, meaning the local address compared against the head-flit destination.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, power of two >= 2, meaning payload-flit buffer entries.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port port  node_port.down  -  upstream link: flit and enable in; ack and rej out.
REQ-006 SHALL have port out_data  output  DATA_W  payload of the buffered flit at the FIFO head.
REQ-007 SHALL have port out_last  output  1  the head entry is a packet's TAIL flit.
REQ-008 SHALL have port out_valid  output  1  the head entry is committed and readable.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the head entry.
REQ-010 SHALL have port busy  output  1  FSM is not in IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, OPEN, CLOSE and REJECT.
REQ-012 IDLE + enable=1 + kind=HEAD + dest==NODE_ADDR SHALL go to OPEN; the head flit is not stored.
REQ-013 IDLE + enable=1 + kind=HEAD + dest!=NODE_ADDR SHALL go to REJECT.
REQ-014 ack SHALL be a registered output, 1 exactly while in OPEN or CLOSE, so it first rises the cycle after the head flit.
REQ-015 rej SHALL be a registered output, 1 exactly while in REJECT.
REQ-016 REJECT SHALL hold until enable=0, then go to IDLE.
REQ-017 OPEN + enable=1 + kind BODY or TAIL SHALL write {data, last=(kind==TAIL)} at the write pointer.
REQ-018 A TAIL write SHALL set the commit pointer to write pointer+1 and go to CLOSE.
REQ-019 CLOSE SHALL hold ack until enable=0, then go to IDLE.
REQ-020 OPEN + write with the FIFO full (committed plus uncommitted entries = FIFO_DEPTH) SHALL drop the flit.
REQ-021 In that overflow case the write pointer SHALL roll back to the commit pointer and the FSM SHALL go to REJECT.
REQ-022 OPEN + enable=0 before TAIL SHALL roll the write pointer back to the commit pointer and go to IDLE, with no rej.
REQ-023 OPEN + enable=1 + kind=HEAD SHALL be treated as a protocol error with the same rollback, going to REJECT.
REQ-024 out_valid SHALL be 1 iff read pointer != commit pointer; uncommitted entries SHALL never be visible.
REQ-025 A read SHALL occur when out_valid=1 and out_ready=1, advancing the read pointer by 1.
REQ-026 A simultaneous read and write in the same cycle SHALL both take effect; a read frees space for a write in the following cycle, not the same cycle.
REQ-027 Pointers SHALL be log2(FIFO_DEPTH)+1 bits with a wrap bit; full is defined as equal indices with differing wrap bits.
REQ-028 Occupancy arithmetic SHALL be modulo 2*FIFO_DEPTH.
REQ-029 A committed packet SHALL become readable the cycle after its TAIL write.

Reset
REQ-030 rst_n=0 SHALL asynchronously force IDLE and set read, write and commit pointers to 0.
REQ-031 rst_n=0 SHALL asynchronously force ack=0, rej=0, out_valid=0 and busy=0.
REQ-032 Reset asserted mid-packet SHALL discard all buffered entries; FIFO storage SHALL NOT require reset.
REQ-033 After reset release, the first valid action SHALL be a HEAD accepted in IDLE on the first rising edge.

Structure
REQ-034 flit_t, flit_kind_t (HEAD, BODY, TAIL), DATA_W, ADDR_W and the destination-field position within a head flit SHALL live in package noc_types.
REQ-035 Storage, pointers and commit/rollback SHALL form one sub-module, sink_fifo; the FSM and the ack/rej registers SHALL stay in node_sink.

Verification
REQ-036 Test: HEAD(dest=NODE_ADDR), BODY 0xA1, TAIL 0xA2, then enable=0 -> ack=1 from cycle 2 until enable drops; out_data 0xA1 then 0xA2 with out_last=0 then 1.
REQ-037 Test: HEAD(dest!=NODE_ADDR) held 3 cycles -> rej=1 from the next cycle until enable=0; ack stays 0; FIFO stays empty.
REQ-038 Test: FIFO_DEPTH=8, out_ready=0, HEAD plus 9 BODY flits -> rej on the cycle after the 9th; out_valid stays 0.
REQ-039 Test: after REQ-038, a new 3-flit packet -> accepted and read out intact.
REQ-040 Test: HEAD, BODY, then enable=0 -> return to IDLE, rej=0, out_valid stays 0; the next packet is delivered without stale data.
REQ-041 Test: rst_n pulsed low mid-packet with 2 committed entries pending -> ack, rej, out_valid and busy fall immediately; nothing is read after reset.
